rsa_modexp: RTL and testbench
=============================

RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of message, modulus and result (legal range 4..64).
REQ-002 SHALL have parameter EXP_WIDTH, default 16: bit width of the exponent (legal range 2..64).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port msg  input  WIDTH  message M (plain text or cipher text).
REQ-008 SHALL have port exp  input  EXP_WIDTH  exponent (e for encrypt, d for decrypt).
REQ-009 SHALL have port modulus  input  WIDTH  modulus n.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  M^exp mod n.
REQ-013 SHALL have port err  output  1  qualified by out_valid; set when modulus < 2.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL capture msg, exp and modulus on a clock edge where in_valid && in_ready; inputs are ignored at all other times.
REQ-016 SHALL drive in_ready high only in IDLE.
REQ-017 SHALL use FSM states IDLE, REDUCE, SQUARE, MULT, NEXT and DONE.
REQ-018 SHALL transition IDLE->REDUCE on accept, or IDLE->DONE with err=1 and result=0 when the captured modulus < 2.
REQ-019 SHALL in REDUCE compute Mr = M mod n as modmul(M,1); acc := 1; bit index i := EXP_WIDTH-1.
REQ-020 SHALL in SQUARE set acc := modmul(acc,acc), then go to MULT if exp[i]=1, else to NEXT.
REQ-021 SHALL in MULT set acc := modmul(acc,Mr), then go to NEXT.
REQ-022 SHALL in NEXT go to DONE if i=0, else decrement i and go to SQUARE; NEXT lasts 1 cycle.
REQ-023 SHALL implement modmul(a,b) as interleaved shift-add MSB-first over the WIDTH bits of a: r := 2r; if r>=n then r -= n; if a_bit then r += b; if r>=n then r -= n. This requires b<n, uses an internal width of WIDTH+2 and takes exactly WIDTH cycles plus a 1-cycle done pulse.
REQ-024 SHALL produce result=1 for exp=0 (n>=2); msg>=n SHALL be handled by REDUCE; msg=0 SHALL give 0 for exp>0.
REQ-025 SHALL take a total latency from accept to out_valid of (WIDTH+1)*(1+EXP_WIDTH+popcount(exp)) + EXP_WIDTH + 1 cycles.
REQ-026 SHALL hold out_valid, result and err stable in DONE until out_ready; on out_valid && out_ready, return to IDLE next cycle, with in_ready high that cycle.
REQ-027 SHALL keep the result unaffected by in_valid activity while busy.

Reset
REQ-028 SHALL on rst, regardless of clock or state (including mid-computation), force IDLE, in_ready=1 after release, out_valid=0, result=0, err=0, busy=0, and clear acc, Mr, i and modmul state.
REQ-029 SHALL discard any operation in progress at reset and never emit a partial result.

Structure
REQ-030 SHALL place the FSM state encoding and the constant MIN_MODULUS=2 in shared package rsa_pkg.
REQ-031 SHALL implement modmul as sub-module rsa_modmul (parameter WIDTH; start/done handshake; a, b, n inputs; product output), instantiated once and time-shared by REDUCE, SQUARE and MULT.

Verification
REQ-032 SHALL pass encrypt: WIDTH=16, msg=72, exp=3, n=33 -> result=18, err=0, latency per REQ-025.
REQ-033 SHALL pass decrypt: msg=18, exp=7, n=33 -> result=6.
REQ-034 SHALL pass wide case: msg=4, exp=13, n=497 -> 445; also exp=0, n=497 -> 1.
REQ-035 SHALL pass error case: n=1 or n=0 -> out_valid with err=1, result=0 within 2 cycles of accept.
REQ-036 SHALL pass backpressure: out_ready held low 20 cycles -> result stable and in_ready=0 throughout; in_valid pulses during busy are ignored.
REQ-037 SHALL pass reset mid-run: rst asserted halfway through msg=18, exp=7 -> immediate IDLE, out_valid=0; next op msg=72, exp=3, n=33 -> 18.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA modular exponentiation block.
// FSM state encoding and the smallest legal modulus.
package rsa_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REDUCE = 3'd1;
  localparam logic [2:0] S_SQUARE = 3'd2;
  localparam logic [2:0] S_MULT   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int MIN_MODULUS = 2;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved shift-add modular multiplier, MSB-first over a.
// WIDTH iteration cycles after start, then a 1-cycle done pulse.
module rsa_modmul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] n_i,
  output logic             done_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q, b_q, n_q, r_q, r_d;
  logic [CW-1:0]    cnt_q;
  logic             run_q, done_q;
  logic [WIDTH+1:0] nx, t1, t2, t3;

  // One iteration: double, reduce, conditionally add b, reduce.
  always_comb begin
    nx  = {2'b00, n_q};
    t1  = {1'b0, r_q, 1'b0};
    t2  = (t1 >= nx) ? t1 - nx : t1;
    t3  = a_q[WIDTH-1] ? t2 + {2'b00, b_q} : t2;
    r_d = WIDTH'((t3 >= nx) ? t3 - nx : t3);
  end

  // Operand capture, iteration counter and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      n_q    <= n_i;
      r_q    <= '0;
      cnt_q  <= CW'(WIDTH);
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else if (run_q) begin
      r_q   <= r_d;
      a_q   <= a_q << 1;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign p_o    = r_q;

endmodule

// File: rtl/rsa_modexp.sv
// Left-to-right square-and-multiply modular exponentiation.
// One time-shared rsa_modmul serves REDUCE, SQUARE and MULT.
module rsa_modexp
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic                 busy
);

  localparam int IW = $clog2(EXP_WIDTH);

  logic [2:0]           state_q, state_d;
  logic [WIDTH-1:0]     msg_q, n_q, mr_q, acc_q, res_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IW-1:0]        idx_q;
  logic                 pend_q, err_q, bad_mod;

  logic                 mm_start, mm_done;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_p;

  assign bad_mod = modulus < WIDTH'(MIN_MODULUS);

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk    (clk),
    .rst    (rst),
    .start_i(mm_start),
    .a_i    (mm_a),
    .b_i    (mm_b),
    .n_i    (n_q),
    .done_o (mm_done),
    .p_o    (mm_p)
  );

  // Next state plus multiplier launch, issued on the edge a step begins.
  always_comb begin
    state_d  = state_q;
    mm_start = 1'b0;
    mm_a     = acc_q;
    mm_b     = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid)
          state_d = bad_mod ? S_DONE : S_REDUCE;
      end
      S_REDUCE: begin
        if (pend_q) begin
          mm_start = 1'b1;
          mm_a     = msg_q;
          mm_b     = WIDTH'(1);
        end else if (mm_done) begin
          state_d  = S_SQUARE;
          mm_start = 1'b1;
          mm_a     = WIDTH'(1);
          mm_b     = WIDTH'(1);
        end
      end
      S_SQUARE: begin
        if (mm_done) begin
          if (exp_q[idx_q]) begin
            state_d  = S_MULT;
            mm_start = 1'b1;
            mm_a     = mm_p;
            mm_b     = mr_q;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_MULT: begin
        if (mm_done)
          state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_SQUARE;
          mm_start = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: operands, reduced message, accumulator, result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      msg_q   <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      mr_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            msg_q <= msg;
            exp_q <= exp;
            n_q   <= modulus;
            err_q <= bad_mod;
            res_q <= '0;
            pend_q <= ~bad_mod;
          end
        end
        S_REDUCE: begin
          pend_q <= 1'b0;
          if (mm_done) begin
            mr_q  <= mm_p;
            acc_q <= WIDTH'(1);
            idx_q <= IW'(EXP_WIDTH - 1);
          end
        end
        S_SQUARE, S_MULT: begin
          if (mm_done)
            acc_q <= mm_p;
        end
        S_NEXT: begin
          if (idx_q == '0)
            res_q <= acc_q;
          else
            idx_q <= idx_q - IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Directed self-checking bench for rsa_modexp (WIDTH=16, EXP_WIDTH=16).
// Latency expectations: 17*(17+popcount(exp)) + 17.
module tb_rsa_modexp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] msg;
  logic [15:0] exp;
  logic [15:0] modulus;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam int LIMIT = 2000;

  rsa_modexp #(.WIDTH(16), .EXP_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .msg      (msg),
    .exp      (exp),
    .modulus  (modulus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Issue one operand set and wait (bounded) for out_valid.
  task automatic do_op(input logic [15:0] m, input logic [15:0] e,
                       input logic [15:0] n, output int cyc,
                       output logic tmo);
    @(negedge clk);
    msg = m; exp = e; modulus = n; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    tmo = !out_valid;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    msg = '0; exp = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0 ||
        err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs ov=%b busy=%b res=%0d err=%b want 0/0/0/0",
               out_valid, busy, result, err);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_encrypt();
    int c; logic t;
    do_op(16'd72, 16'd3, 16'd33, c, t);
    checks++;
    if (t || result !== 16'd18 || err !== 1'b0) begin
      failures++;
      $display("FAIL encrypt tmo=%b res=%0d err=%b want res=18 err=0",
               t, result, err);
    end
    checks++;
    if (c !== 340) begin
      failures++;
      $display("FAIL encrypt_latency got=%0d want=340", c);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL encrypt_return ir=%b ov=%b busy=%b want 1/0/0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_decrypt();
    int c; logic t;
    do_op(16'd18, 16'd7, 16'd33, c, t);
    checks++;
    if (t || result !== 16'd6 || err !== 1'b0 || c !== 357) begin
      failures++;
      $display("FAIL decrypt tmo=%b res=%0d err=%b lat=%0d want 6/0/357",
               t, result, err, c);
    end
    consume();
  endtask

  task automatic test_wide();
    int c; logic t;
    do_op(16'd4, 16'd13, 16'd497, c, t);
    checks++;
    if (t || result !== 16'd445 || c !== 357) begin
      failures++;
      $display("FAIL wide tmo=%b res=%0d lat=%0d want 445/357",
               t, result, c);
    end
    consume();
    do_op(16'd4, 16'd0, 16'd497, c, t);
    checks++;
    if (t || result !== 16'd1 || err !== 1'b0 || c !== 306) begin
      failures++;
      $display("FAIL exp_zero tmo=%b res=%0d err=%b lat=%0d want 1/0/306",
               t, result, err, c);
    end
    consume();
  endtask

  task automatic test_msg_edges();
    int c; logic t;
    do_op(16'd105, 16'd3, 16'd33, c, t);
    checks++;
    if (t || result !== 16'd18) begin
      failures++;
      $display("FAIL msg_ge_n tmo=%b res=%0d want 18", t, result);
    end
    consume();
    do_op(16'd0, 16'd5, 16'd33, c, t);
    checks++;
    if (t || result !== 16'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL msg_zero tmo=%b res=%0d err=%b want 0/0",
               t, result, err);
    end
    consume();
    do_op(16'd65535, 16'd2, 16'd65521, c, t);
    checks++;
    if (t || result !== 16'd196) begin
      failures++;
      $display("FAIL msg_max tmo=%b res=%0d want 196", t, result);
    end
    consume();
  endtask

  task automatic test_error();
    int c; logic t;
    do_op(16'd5, 16'd3, 16'd1, c, t);
    checks++;
    if (t || err !== 1'b1 || result !== 16'd0 || c > 2) begin
      failures++;
      $display("FAIL err_n1 tmo=%b err=%b res=%0d lat=%0d want 1/0/<=2",
               t, err, result, c);
    end
    consume();
    do_op(16'd5, 16'd3, 16'd0, c, t);
    checks++;
    if (t || err !== 1'b1 || result !== 16'd0 || c > 2) begin
      failures++;
      $display("FAIL err_n0 tmo=%b err=%b res=%0d lat=%0d want 1/0/<=2",
               t, err, result, c);
    end
    consume();
    do_op(16'd5, 16'd3, 16'd33, c, t);
    checks++;
    if (t || err !== 1'b0 || result !== 16'd26) begin
      failures++;
      $display("FAIL err_clear tmo=%b err=%b res=%0d want 0/26",
               t, err, result);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int c; int bad;
    @(negedge clk);
    msg = 16'd72; exp = 16'd3; modulus = 16'd33; in_valid = 1'b1;
    @(posedge clk); #1;
    c = 0;
    while (!out_valid && c < LIMIT) begin
      @(negedge clk);
      in_valid = (c % 7 == 3);
      msg = 16'd18; exp = 16'd7; modulus = 16'd497;
      @(posedge clk); #1;
      c++;
    end
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (!out_valid || c !== 340) begin
      failures++;
      $display("FAIL bp_latency ov=%b lat=%0d want 1/340", out_valid, c);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = k[0];
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 16'd18 || in_ready !== 1'b0)
        bad++;
    end
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d want 0 res=%0d", bad, result);
    end
    consume();
  endtask

  task automatic test_reset_midrun();
    int c; logic t;
    @(negedge clk);
    msg = 16'd18; exp = 16'd7; modulus = 16'd33; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (178) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0 ||
        err !== 1'b0) begin
      failures++;
      $display("FAIL midrun_rst ov=%b busy=%b res=%0d err=%b want 0/0/0/0",
               out_valid, busy, result, err);
    end
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_ready got=%b want=1", in_ready);
    end
    do_op(16'd72, 16'd3, 16'd33, c, t);
    checks++;
    if (t || result !== 16'd18 || c !== 340) begin
      failures++;
      $display("FAIL midrun_next tmo=%b res=%0d lat=%0d want 18/340",
               t, result, c);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_wide();
    test_msg_edges();
    test_error();
    test_backpressure();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
